// File: rtl/idma_legalizer_burst_chopper.sv
// Splits one 1D transfer into a stream of bursts. A burst never exceeds the
// remaining length and never crosses a page boundary on either the source or
// the destination side. Page distances come from external splitters that see
// only cur_*_addr_o, so burst outputs stay stable under backpressure.
module idma_legalizer_burst_chopper #(
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned LenWidth     = 32,
  parameter int unsigned PageLenWidth = 13
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [AddrWidth-1:0]    req_src_addr_i,
  input  logic [AddrWidth-1:0]    req_dst_addr_i,
  input  logic [LenWidth-1:0]     req_length_i,
  output logic [AddrWidth-1:0]    cur_src_addr_o,
  output logic [AddrWidth-1:0]    cur_dst_addr_o,
  input  logic [PageLenWidth-1:0] src_bytes_to_pb_i,
  input  logic [PageLenWidth-1:0] dst_bytes_to_pb_i,
  output logic                    burst_valid_o,
  input  logic                    burst_ready_i,
  output logic [AddrWidth-1:0]    burst_src_addr_o,
  output logic [AddrWidth-1:0]    burst_dst_addr_o,
  output logic [PageLenWidth-1:0] burst_len_o,
  output logic                    burst_last_o,
  output logic                    busy_o
);

  typedef enum logic {
    IDLE = 1'b0,
    CHOP = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] cur_src_q, cur_src_d;
  logic [AddrWidth-1:0] cur_dst_q, cur_dst_d;
  logic [LenWidth-1:0]  rem_q, rem_d;

  logic [LenWidth-1:0]  src_pb_ext;
  logic [LenWidth-1:0]  dst_pb_ext;
  logic [LenWidth-1:0]  len_full;
  logic                 is_last;

  // Burst length: smallest of remaining bytes and both page distances
  always_comb begin
    src_pb_ext = LenWidth'(src_bytes_to_pb_i);
    dst_pb_ext = LenWidth'(dst_bytes_to_pb_i);
    len_full   = rem_q;
    if (src_pb_ext < len_full) len_full = src_pb_ext;
    if (dst_pb_ext < len_full) len_full = dst_pb_ext;
    is_last    = (rem_q == len_full);
  end

  // Next-state and handshake outputs; reset masks every control output
  always_comb begin
    state_d       = state_q;
    cur_src_d     = cur_src_q;
    cur_dst_d     = cur_dst_q;
    rem_d         = rem_q;
    req_ready_o   = 1'b0;
    burst_valid_o = 1'b0;
    burst_last_o  = 1'b0;
    busy_o        = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready_o = !rst_i;
        // Zero-length requests are accepted and dropped
        if (req_valid_i && (req_length_i != '0)) begin
          cur_src_d = req_src_addr_i;
          cur_dst_d = req_dst_addr_i;
          rem_d     = req_length_i;
          state_d   = CHOP;
        end
      end
      CHOP: begin
        burst_valid_o = !rst_i;
        busy_o        = !rst_i;
        burst_last_o  = !rst_i && is_last;
        if (burst_valid_o && burst_ready_i) begin
          cur_src_d = cur_src_q + AddrWidth'(len_full);
          cur_dst_d = cur_dst_q + AddrWidth'(len_full);
          rem_d     = rem_q - len_full;
          if (is_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and address/length registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cur_src_q <= '0;
      cur_dst_q <= '0;
      rem_q     <= '0;
    end else begin
      state_q   <= state_d;
      cur_src_q <= cur_src_d;
      cur_dst_q <= cur_dst_d;
      rem_q     <= rem_d;
    end
  end

  assign cur_src_addr_o   = cur_src_q;
  assign cur_dst_addr_o   = cur_dst_q;
  assign burst_src_addr_o = cur_src_q;
  assign burst_dst_addr_o = cur_dst_q;
  assign burst_len_o      = PageLenWidth'(len_full);

endmodule
